// File: rtl/tipi_shift_master_if.sv
// rtl/tipi_shift_master_if.sv - host command/response and TIPI link signals for tipi_shift_master
// master = the shift engine, slave = host plus TIPI side.
interface tipi_shift_master_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic       cmd_ctrl;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_parity_err;
   logic       busy;
   logic       r_clk;
   logic       r_le;
   logic       r_rt;
   logic       r_cd;
   logic       r_dout;
   logic       r_din;

   modport master (
      input  cmd_valid, cmd_write, cmd_ctrl, cmd_data, r_din,
      output cmd_ready, rsp_valid, rsp_data, rsp_parity_err, busy,
             r_clk, r_le, r_rt, r_cd, r_dout
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_ctrl, cmd_data, r_din,
      input  cmd_ready, rsp_valid, rsp_data, rsp_parity_err, busy,
             r_clk, r_le, r_rt, r_cd, r_dout
   );
endinterface

// File: rtl/tipi_shift_master.sv
// rtl/tipi_shift_master.sv - TIPI register-exchange link master, one byte per command
// Timed sequence SETUP -> (LOAD) -> 8 x SHIFT -> (LATCH) -> DONE, every link output registered.
module tipi_shift_master #(
   parameter int CLK_DIV = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   tipi_shift_master_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_LOAD, S_SHIFT, S_LATCH, S_DONE
   } state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_q, state_n;
   logic [7:0] div_q, div_n;
   logic       phase_q, phase_n;
   logic [2:0] bit_q, bit_n;
   logic       wr_q, wr_n;
   logic [7:0] data_q, data_n;
   logic [7:0] rx_q, rx_n;
   logic       r_clk_q, r_clk_n;
   logic       le_q, le_n;
   logic       rt_q, rt_n;
   logic       cd_q, cd_n;
   logic       dout_q, dout_n;
   logic       ready_q, ready_n;
   logic       busy_q, busy_n;
   logic       rsp_valid_q, rsp_valid_n;
   logic [7:0] rsp_data_q, rsp_data_n;
   logic       perr_q, perr_n;

   logic       last_div;
   logic [7:0] div_inc;

   assign last_div = (div_q == DIV_LAST);
   assign div_inc  = last_div ? 8'd0 : div_q + 8'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         div_q       <= 8'd0;
         phase_q     <= 1'b0;
         bit_q       <= 3'd0;
         wr_q        <= 1'b0;
         data_q      <= 8'd0;
         rx_q        <= 8'd0;
         r_clk_q     <= 1'b0;
         le_q        <= 1'b0;
         rt_q        <= 1'b0;
         cd_q        <= 1'b0;
         dout_q      <= 1'b0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'd0;
         perr_q      <= 1'b0;
      end else begin
         state_q     <= state_n;
         div_q       <= div_n;
         phase_q     <= phase_n;
         bit_q       <= bit_n;
         wr_q        <= wr_n;
         data_q      <= data_n;
         rx_q        <= rx_n;
         r_clk_q     <= r_clk_n;
         le_q        <= le_n;
         rt_q        <= rt_n;
         cd_q        <= cd_n;
         dout_q      <= dout_n;
         ready_q     <= ready_n;
         busy_q      <= busy_n;
         rsp_valid_q <= rsp_valid_n;
         rsp_data_q  <= rsp_data_n;
         perr_q      <= perr_n;
      end
   end

   always_comb begin
      state_n     = state_q;
      div_n       = div_q;
      phase_n     = phase_q;
      bit_n       = bit_q;
      wr_n        = wr_q;
      data_n      = data_q;
      rx_n        = rx_q;
      r_clk_n     = r_clk_q;
      le_n        = le_q;
      rt_n        = rt_q;
      cd_n        = cd_q;
      dout_n      = dout_q;
      ready_n     = ready_q;
      busy_n      = busy_q;
      rsp_valid_n = 1'b0;
      rsp_data_n  = rsp_data_q;
      perr_n      = perr_q;

      case (state_q)
         S_IDLE: begin
            ready_n = 1'b1;
            div_n   = 8'd0;
            phase_n = 1'b0;
            if (bus.cmd_valid && ready_q) begin
               state_n = S_SETUP;
               ready_n = 1'b0;
               busy_n  = 1'b1;
               wr_n    = bus.cmd_write;
               data_n  = bus.cmd_data;
               rt_n    = ~bus.cmd_write;
               cd_n    = ~bus.cmd_ctrl;
            end
         end

         S_SETUP: begin
            div_n = div_inc;
            if (last_div) begin
               if (wr_q) begin
                  state_n = S_SHIFT;
                  bit_n   = 3'd7;
                  dout_n  = data_q[7];
               end else begin
                  state_n = S_LOAD;
                  le_n    = 1'b1;
               end
            end
         end

         S_LOAD, S_SHIFT, S_LATCH: begin
            div_n = div_inc;
            if (last_div && !phase_q) begin
               phase_n = 1'b1;
               r_clk_n = 1'b1;
            end
            // End of a slot: r_clk falls and the next bit/phase is set up on the same edge.
            if (last_div && phase_q) begin
               phase_n = 1'b0;
               r_clk_n = 1'b0;
               if (state_q == S_LOAD) begin
                  state_n = S_SHIFT;
                  bit_n   = 3'd7;
                  le_n    = 1'b0;
               end else if (state_q == S_SHIFT) begin
                  if (!wr_q) begin
                     rx_n[bit_q] = bus.r_din;
                  end
                  if (bit_q == 3'd0) begin
                     if (wr_q) begin
                        state_n = S_LATCH;
                        le_n    = 1'b1;
                        dout_n  = 1'b0;
                     end else begin
                        state_n     = S_DONE;
                        rsp_valid_n = 1'b1;
                        rsp_data_n  = rx_n;
                        perr_n      = 1'b0;
                     end
                  end else begin
                     bit_n = bit_q - 3'd1;
                     if (wr_q) begin
                        dout_n = data_q[bit_q - 3'd1];
                     end
                  end
               end else begin
                  state_n     = S_DONE;
                  le_n        = 1'b0;
                  rsp_valid_n = 1'b1;
                  rsp_data_n  = data_q;
                  perr_n      = bus.r_din ^ (^data_q);
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
            busy_n  = 1'b0;
            ready_n = 1'b1;
            div_n   = 8'd0;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   assign bus.cmd_ready      = ready_q;
   assign bus.busy           = busy_q;
   assign bus.rsp_valid      = rsp_valid_q;
   assign bus.rsp_data       = rsp_data_q;
   assign bus.rsp_parity_err = perr_q;
   assign bus.r_clk          = r_clk_q;
   assign bus.r_le           = le_q;
   assign bus.r_rt           = rt_q;
   assign bus.r_cd           = cd_q;
   assign bus.r_dout         = dout_q;

endmodule

// File: tb/tb_tipi_shift_master.sv
// tb/tb_tipi_shift_master.sv - directed bench for tipi_shift_master with a TIPI register model
// Instance dut4 runs CLK_DIV=4, dut1 runs CLK_DIV=1; index 0/1 of model arrays follow that order.
module tb_tipi_shift_master;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   tipi_shift_master_if bus4();
   tipi_shift_master_if bus1();

   tipi_shift_master #(.CLK_DIV(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.master));
   tipi_shift_master #(.CLK_DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.master));

   wire [1:0] m_clk  = {bus1.r_clk, bus4.r_clk};
   wire [1:0] m_le   = {bus1.r_le, bus4.r_le};
   wire [1:0] m_rt   = {bus1.r_rt, bus4.r_rt};
   wire [1:0] m_dout = {bus1.r_dout, bus4.r_dout};
   wire [1:0] m_rsp  = {bus1.rsp_valid, bus4.rsp_valid};

   logic [7:0] tx [2];
   logic       par [2];
   logic [7:0] sr [2];
   logic [7:0] wbits [2];
   logic [1:0] prev_clk, prev_le;
   int         le_cyc [2];
   int         hi_cyc [2];
   int         rise_cnt [2];
   int         rsp_cnt [2];

   // TIPI side: parallel load on a rising r_clk with r_le, shift after each plain shift slot.
   assign bus4.r_din = m_rt[0] ? sr[0][7] : par[0];
   assign bus1.r_din = m_rt[1] ? sr[1][7] : par[1];

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (m_le[i]) le_cyc[i] <= le_cyc[i] + 1;
         if (m_clk[i]) hi_cyc[i] <= hi_cyc[i] + 1;
         if (m_rsp[i]) rsp_cnt[i] <= rsp_cnt[i] + 1;
         if (m_clk[i] && !prev_clk[i]) begin
            if (m_le[i] && m_rt[i]) sr[i] <= tx[i];
            if (!m_le[i]) begin
               rise_cnt[i] <= rise_cnt[i] + 1;
               wbits[i]    <= {wbits[i][6:0], m_dout[i]};
            end
         end
         if (!m_clk[i] && prev_clk[i] && !prev_le[i]) sr[i] <= sr[i] << 1;
      end
      prev_clk <= m_clk;
      prev_le  <= m_le;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cmd4(input logic wr, input logic ctrl, input logic [7:0] data, input string tag);
      int lat;
      int le0;
      int r0;
      @(negedge clk);
      bus4.cmd_valid = 1'b1;
      bus4.cmd_write = wr;
      bus4.cmd_ctrl  = ctrl;
      bus4.cmd_data  = data;
      le0 = le_cyc[0];
      r0  = rise_cnt[0];
      @(posedge clk);
      #1;
      bus4.cmd_valid = 1'b0;
      chk({tag, "_accept"}, {bus4.r_rt, bus4.r_cd, bus4.busy, bus4.cmd_ready},
          {~wr, ~ctrl, 1'b1, 1'b0});
      lat = -1;
      for (int k = 1; k <= 200; k++) begin
         @(posedge clk);
         #1;
         if (bus4.rsp_valid) begin
            lat = k;
            break;
         end
      end
      chk({tag, "_latency"}, lat, 76);
      @(posedge clk);
      #1;
      chk({tag, "_after_done"}, {bus4.rsp_valid, bus4.busy, bus4.cmd_ready}, 3'b001);
      chk({tag, "_le_cycles"}, le_cyc[0] - le0, 8);
      chk({tag, "_shift_edges"}, rise_cnt[0] - r0, 8);
   endtask

   int acc1, acc2, rsp1, rsp2, le1, h1, r0, n0;
   logic [7:0] d1, d2;
   logic e1, e2, pb;
   logic [4:0] idle_acc;

   initial begin
      reset = 1'b1;
      bus4.cmd_valid = 1'b0; bus4.cmd_write = 1'b0; bus4.cmd_ctrl = 1'b0; bus4.cmd_data = 8'h00;
      bus1.cmd_valid = 1'b0; bus1.cmd_write = 1'b0; bus1.cmd_ctrl = 1'b0; bus1.cmd_data = 8'h00;
      tx[0] = 8'h00; tx[1] = 8'h00; par[0] = 1'b0; par[1] = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs4", {bus4.r_clk, bus4.r_le, bus4.r_rt, bus4.r_cd, bus4.r_dout, bus4.rsp_valid,
                          bus4.rsp_parity_err, bus4.busy, bus4.cmd_ready, bus4.rsp_data}, 0);
      chk("reset_ready1", bus1.cmd_ready, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("ready_after_reset", {bus4.cmd_ready, bus1.cmd_ready}, 2'b11);
      idle_acc = 5'd0;
      repeat (6) begin
         @(negedge clk);
         idle_acc = idle_acc | {bus4.r_clk, bus4.r_le, bus4.r_rt, bus4.r_cd, bus4.r_dout};
      end
      chk("idle_link", idle_acc, 5'd0);

      tx[0] = 8'hA5;
      cmd4(1'b0, 1'b0, 8'h00, "rd_td");
      chk("rd_td_data", {bus4.rsp_parity_err, bus4.rsp_data}, {1'b0, 8'hA5});

      par[0] = 1'b0;
      cmd4(1'b1, 1'b1, 8'h3C, "wr_rc");
      chk("wr_rc_serial", wbits[0], 8'h3C);
      chk("wr_rc_rsp", {bus4.rsp_parity_err, bus4.rsp_data}, {1'b0, 8'h3C});

      par[0] = 1'b1;
      cmd4(1'b1, 1'b1, 8'h3C, "wr_rc_p1");
      chk("wr_rc_p1_rsp", {bus4.rsp_parity_err, bus4.rsp_data}, {1'b1, 8'h3C});

      // cmd_valid pulses while busy must not start a second command
      par[0] = 1'b0;
      n0 = rsp_cnt[0];
      @(negedge clk);
      bus4.cmd_valid = 1'b1; bus4.cmd_write = 1'b1; bus4.cmd_ctrl = 1'b0; bus4.cmd_data = 8'h07;
      @(negedge clk);
      bus4.cmd_valid = 1'b0;
      repeat (10) @(negedge clk);
      bus4.cmd_valid = 1'b1; bus4.cmd_data = 8'hEE;
      @(negedge clk);
      bus4.cmd_valid = 1'b0;
      repeat (30) @(negedge clk);
      bus4.cmd_valid = 1'b1; bus4.cmd_write = 1'b0;
      @(negedge clk);
      bus4.cmd_valid = 1'b0;
      repeat (120) @(negedge clk);
      chk("busy_pulse_rsp_count", rsp_cnt[0] - n0, 1);
      chk("busy_pulse_rsp", {bus4.rsp_parity_err, bus4.rsp_data}, {1'b1, 8'h07});

      // reset during SHIFT bit 3 of a write of 8'hFF
      n0 = rsp_cnt[0];
      r0 = rise_cnt[0];
      @(negedge clk);
      bus4.cmd_valid = 1'b1; bus4.cmd_write = 1'b1; bus4.cmd_ctrl = 1'b0; bus4.cmd_data = 8'hFF;
      @(negedge clk);
      bus4.cmd_valid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (rise_cnt[0] - r0 >= 5) break;
      end
      chk("abort_bit3_reached", {rise_cnt[0] - r0, 3'b0, bus4.r_clk, bus4.r_dout}, {32'd5, 3'b0, 1'b1, 1'b1});
      reset = 1'b1;
      #1;
      chk("abort_link", {bus4.r_clk, bus4.r_le, bus4.r_dout, bus4.busy, bus4.rsp_valid}, 5'd0);
      repeat (30) @(negedge clk);
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("abort_no_rsp", rsp_cnt[0] - n0, 0);
      tx[0] = 8'h5A;
      cmd4(1'b0, 1'b0, 8'h00, "rd_after_abort");
      chk("rd_after_abort_data", {bus4.rsp_parity_err, bus4.rsp_data}, {1'b0, 8'h5A});

      // CLK_DIV=1 back-to-back: write RD 8'hFF then read TC 8'h01 with cmd_valid held
      tx[1] = 8'h01; par[1] = 1'b0;
      le1 = le_cyc[1]; h1 = hi_cyc[1];
      acc1 = -1; acc2 = -1; rsp1 = -1; rsp2 = -1;
      d1 = 8'h00; d2 = 8'h00; e1 = 1'b1; e2 = 1'b1; pb = 1'b0;
      @(negedge clk);
      bus1.cmd_valid = 1'b1; bus1.cmd_write = 1'b1; bus1.cmd_ctrl = 1'b0; bus1.cmd_data = 8'hFF;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk);
         #1;
         if (bus1.busy && !pb) begin
            if (acc1 < 0) begin
               acc1 = k;
               chk("b2b_sel1", {bus1.r_rt, bus1.r_cd}, 2'b01);
               bus1.cmd_write = 1'b0; bus1.cmd_ctrl = 1'b1; bus1.cmd_data = 8'h00;
            end else begin
               acc2 = k;
               chk("b2b_sel2", {bus1.r_rt, bus1.r_cd}, 2'b10);
               bus1.cmd_valid = 1'b0;
            end
         end
         if (bus1.rsp_valid) begin
            if (rsp1 < 0) begin
               rsp1 = k; d1 = bus1.rsp_data; e1 = bus1.rsp_parity_err;
               chk("b2b_serial", wbits[1], 8'hFF);
            end else begin
               rsp2 = k; d2 = bus1.rsp_data; e2 = bus1.rsp_parity_err;
            end
         end
         pb = bus1.busy;
         if (rsp2 >= 0) break;
      end
      bus1.cmd_valid = 1'b0;
      chk("b2b_acc1", acc1, 1);
      chk("b2b_rsp1", rsp1, 20);
      chk("b2b_acc2", acc2, 22);
      chk("b2b_rsp2", rsp2, 41);
      chk("b2b_wr_rsp", {e1, d1}, {1'b0, 8'hFF});
      chk("b2b_rd_rsp", {e2, d2}, {1'b0, 8'h01});
      chk("b2b_rclk_high", hi_cyc[1] - h1, 18);
      chk("b2b_le_cycles", le_cyc[1] - le1, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/tipi_shift_master.md
Name: tipi_shift_master

Overview:
Serial-protocol master for the TIPI register-exchange link. It generates r_clk, r_le, r_rt, r_cd and r_dout to move one byte per command between a host-side byte interface and the four TIPI shift registers:
- TD/TC are read (TI→RPi direction).
- RD/RC are written (RPi→TI direction).

It replaces software bit-banging with a fixed, timed sequence. It is used in the standalone-host and speech-board builds, and as the bench driver for the CPLD top.

Parameters:
CLK_DIV, 4, system clocks per r_clk half-period; legal range 1..255.

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_write  input  1  1 = write byte to RD/RC; 0 = read byte from TD/TC
cmd_ctrl  input  1  1 = control register (RC/TC); 0 = data register (RD/TD)
cmd_data  input  8  byte to write; ignored for reads
rsp_valid  output  1  one-cycle completion pulse
rsp_data  output  8  byte read, or echo of the written byte
rsp_parity_err  output  1  write only: returned parity mismatch
busy  output  1  high from accept until the rsp_valid cycle inclusive
r_clk  output  1  link shift clock
r_le  output  1  load/latch enable
r_rt  output  1  0 = RPi→TI register (RD/RC); 1 = TI→RPi register (TD/TC)
r_cd  output  1  0 = control register; 1 = data register
r_dout  output  1  serial data toward the TIPI
r_din  input  1  serial data / parity from the TIPI

Behaviour:
- Reset (asynchronous), all outputs to these values:
  - r_clk=0, r_le=0, r_rt=0, r_cd=0, r_dout=0
  - rsp_valid=0, rsp_data=0, rsp_parity_err=0, busy=0, cmd_ready=0
  - state=IDLE, counters=0
- cmd_ready goes 1 on the first clk edge after reset deasserts.
- Reset asserted mid-operation aborts the transfer immediately; no rsp_valid is produced.
- Accept: cmd_valid && cmd_ready on a rising edge.
  - cmd_write, cmd_ctrl and cmd_data are captured at that edge.
  - cmd_ready drops the same edge.
  - On that edge: r_rt=~cmd_write, r_cd=~cmd_ctrl.
  - r_rt and r_cd hold until the next accept; they change only while r_clk=0.
- Slot: r_clk low for CLK_DIV clocks, then high for CLK_DIV clocks. A divider counter (0..CLK_DIV-1) times each half.
- States:
  - IDLE → SETUP on accept.
  - SETUP: r_clk=0 for CLK_DIV clocks; address settle.
    - Goes to LOAD if read, SHIFT if write.
  - LOAD (read only): one slot with r_le=1 (parallel load). Then → SHIFT; r_le falls with r_clk.
  - SHIFT: 8 slots with r_le=0; a 3-bit bit counter runs 7 down to 0, MSB first.
    - Write: r_dout=cmd_data[bit] is driven at the start of each low half and held through the high half.
    - Read: r_din is sampled in the last clk of each high half into rsp_data[bit].
    - After bit 0: read → DONE; write → LATCH.
  - LATCH (write only): one slot with r_le=1; r_dout=0.
    - r_din (parity) is sampled in the last clk of the high half.
    - rsp_parity_err = sampled r_din XOR (^cmd_data), i.e. even parity over the byte.
    - Then → DONE.
  - DONE: r_clk=0, r_le=0, rsp_valid=1 for exactly one cycle, busy=1.
    - Next edge → IDLE; cmd_ready=1, busy=0.
- Response fields:
  - rsp_data and rsp_parity_err hold until the next rsp_valid.
  - Reads force rsp_parity_err=0.
  - Writes set rsp_data=cmd_data.
- Latency, both directions: rsp_valid is high in the cycle that begins 19*CLK_DIV clocks after the accepting edge. Minimum command spacing is 19*CLK_DIV+2 clocks.
- r_clk has no glitches; all link outputs are registered.
- cmd_valid while not ready is ignored; no queueing.

Test Plan:
- Reset released, CLK_DIV=4 → cmd_ready=1 next edge; all link outputs 0 throughout idle.
- Read TD; bench TIPI model shifts out 8'hA5 → r_rt=1, r_cd=1, r_le high for exactly one slot, then 8 r_clk rising edges; rsp_valid at accept+76 clocks with rsp_data=8'hA5, rsp_parity_err=0.
- Write RC 8'h3C; model returns parity 0 → r_rt=0, r_cd=0, r_dout serial 0,0,1,1,1,1,0,0; r_le slot after the 8th bit; rsp_data=8'h3C, rsp_parity_err=0. Repeat with a parity-1 reply → rsp_parity_err=1.
- CLK_DIV=1, back-to-back write RD 8'hFF then read TC 8'h01 with cmd_valid held high → second accept exactly 2 clocks after the first rsp_valid; r_clk period 2 clocks; both bytes correct.
- Reset asserted during SHIFT bit 3 → r_clk, r_le, r_dout go 0 immediately, no rsp_valid; after release a fresh read returns correct data.
- cmd_valid pulsed while busy → ignored; exactly one rsp_valid per accepted command.
